uart_tx: RTL and testbench

UART transmitter: serialises one byte per frame as start bit, 8 data bits LSB first, optional even/odd parity, and 1 or 2 stop bits onto `Tx`. It is paced by the same oversampling tick (`enable`, from `clk_div`) that drives `Rx`, so both ends share one baud generator. It is the transmit half of the UART, pin-compatible in frame format with `Rx` (`SAMPLE`=16, even parity, 1 stop bit).

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx.sv | 104 ++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: frame constants, FSM state encoding, parity helper
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_SAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int SAMPLE     = UART_SAMPLE,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [UART_DATA_W-1:0] d_in,
  input  logic                   d_in_valid,
  output logic                   ready,
  output logic                   Tx,
  output logic                   tx_done
);

  localparam int              CNT_W     = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SAMPLE - 1);
  localparam logic [2:0]       LAST_DATA = 3'(UART_DATA_W - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e            state;
  logic [CNT_W-1:0]       tick_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   parity_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      ready      <= 1'b1;
      Tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // Line level follows the state one clk later, so every edge lands 1 clk after a tick.
      case (state)
        ST_START:  Tx <= 1'b0;
        ST_DATA:   Tx <= shreg[0];
        ST_PARITY: Tx <= parity_bit;
        default:   Tx <= 1'b1;
      endcase

      if (state == ST_IDLE) begin
        if (d_in_valid && ready) begin
          shreg      <= d_in;
          parity_bit <= calc_parity(d_in, 1'(PARITY_ODD));
          tick_cnt   <= '0;
          bit_idx    <= '0;
          ready      <= 1'b0;
          state      <= ST_START;
        end
      end else if (enable) begin
        if (tick_cnt != LAST_TICK) begin
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          tick_cnt <= '0;
          case (state)
            ST_START: begin
              bit_idx <= '0;
              state   <= ST_DATA;
            end
            ST_DATA: begin
              shreg <= shreg >> 1;
              if (bit_idx == LAST_DATA) begin
                bit_idx <= '0;
                state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
            ST_PARITY: begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end
            ST_STOP: begin
              if (bit_idx == LAST_STOP) begin
                bit_idx <= '0;
                ready   <= 1'b1;
                tx_done <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
            default: begin
              ready <= 1'b1;
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across parity and stop-bit configurations
module tb_uart_tx;

  localparam int DIV    = 4;
  localparam int SAMPLE = 16;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       en_gate;
  logic [7:0] d_in;
  logic       valid   [4];
  logic       ready_v [4];
  logic       tx_v    [4];
  logic       done_v  [4];

  int pen_c [4] = '{1, 1, 0, 1};
  int podd_c[4] = '{0, 1, 0, 0};
  int nst_c [4] = '{1, 1, 1, 2};

  int tests = 0;
  int fails = 0;
  int div_cnt = 0;

  uart_tx #(.SAMPLE(SAMPLE), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d_in(d_in), .d_in_valid(valid[0]),
    .ready(ready_v[0]), .Tx(tx_v[0]), .tx_done(done_v[0]));

  uart_tx #(.SAMPLE(SAMPLE), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d_in(d_in), .d_in_valid(valid[1]),
    .ready(ready_v[1]), .Tx(tx_v[1]), .tx_done(done_v[1]));

  uart_tx #(.SAMPLE(SAMPLE), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d_in(d_in), .d_in_valid(valid[2]),
    .ready(ready_v[2]), .Tx(tx_v[2]), .tx_done(done_v[2]));

  uart_tx #(.SAMPLE(SAMPLE), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d_in(d_in), .d_in_valid(valid[3]),
    .ready(ready_v[3]), .Tx(tx_v[3]), .tx_done(done_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt + 1) % DIV;
      enable  = en_gate && (div_cnt == 0);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i of a byte, straight from the frame format: start, LSB-first data, parity, stops.
  function automatic logic exp_bit(input logic [7:0] b, input int pen, input int podd, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && pen != 0) return logic'(($countones(b) + podd) % 2);
    return 1'b1;
  endfunction

  task automatic do_accept(input int k, input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_v[k] && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", ready_v[k], 8'd1);
    d_in     = b;
    valid[k] = 1'b1;
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    check("tx_idle_at_accept", tx_v[k], 8'd1);
    check("ready_drop", ready_v[k], 8'd0);
  endtask

  // Entered 1 time unit after the accept edge; counts ticks and checks each bit at its centre.
  task automatic frame_check(input int k, input logic [7:0] b, input bit poke, input bit stall,
                             input bit abort);
    int   nbits;
    int   n;
    int   cyc;
    logic e;
    logic saved;
    bit   early;
    bit   finished;
    nbits    = 9 + pen_c[k] + nst_c[k];
    n        = 0;
    cyc      = 0;
    early    = 1'b0;
    finished = 1'b0;
    while (cyc < nbits * SAMPLE * DIV + 200) begin
      @(posedge clk);
      e = enable;
      #1;
      cyc++;
      if (valid[k]) valid[k] = 1'b0;
      if (cyc == 1) check("start_fall", tx_v[k], 8'd0);
      if (!e) continue;
      n++;
      if (n % SAMPLE == SAMPLE / 2)
        check($sformatf("k%0d_byte%02h_bit%0d", k, b, n / SAMPLE), tx_v[k],
              8'(exp_bit(b, pen_c[k], podd_c[k], n / SAMPLE)));
      if (n == nbits * SAMPLE) begin
        check("tx_done_at_end", done_v[k], 8'd1);
        check("ready_at_end", ready_v[k], 8'd1);
        finished = 1'b1;
        break;
      end
      if (done_v[k]) early = 1'b1;
      if (poke && n == 40) begin
        d_in     = 8'hFF;
        valid[k] = 1'b1;
      end
      if (stall && n == 100) begin
        saved   = tx_v[k];
        en_gate = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("stall_hold_tx", tx_v[k], 8'(saved));
        check("stall_no_done", done_v[k], 8'd0);
        en_gate = 1'b1;
      end
      if (abort && n == SAMPLE * 4 + SAMPLE / 2) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tx_high", tx_v[k], 8'd1);
        check("abort_ready", ready_v[k], 8'd1);
        check("abort_no_done", done_v[k], 8'd0);
        rst_n    = 1'b1;
        finished = 1'b1;
        break;
      end
    end
    check("frame_finished", 8'(finished), 8'd1);
    check("no_early_done", 8'(early), 8'd0);
  endtask

  task automatic post_done(input int k);
    @(posedge clk);
    #1;
    check("done_one_clk", done_v[k], 8'd0);
  endtask

  task automatic idle_watch(input int k, input int ncyc);
    bit bad;
    bad = 1'b0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (tx_v[k] !== 1'b1 || done_v[k] !== 1'b0 || ready_v[k] !== 1'b1) bad = 1'b1;
    end
    check($sformatf("idle_k%0d", k), 8'(bad), 8'd0);
  endtask

  initial begin
    logic [7:0] rb;
    int         rk;
    rst_n   = 1'b0;
    en_gate = 1'b1;
    d_in    = 8'h00;
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_tx_%0d", i), tx_v[i], 8'd1);
      check($sformatf("reset_ready_%0d", i), ready_v[i], 8'd1);
      check($sformatf("reset_done_%0d", i), done_v[i], 8'd0);
    end
    rst_n = 1'b1;
    idle_watch(0, 60);

    do_accept(0, 8'h69);
    frame_check(0, 8'h69, 1'b0, 1'b0, 1'b0);
    post_done(0);

    for (int k = 0; k < 3; k++) begin
      do_accept(k, 8'h07);
      frame_check(k, 8'h07, 1'b0, 1'b0, 1'b0);
      post_done(k);
    end

    // Back-to-back frames with a dropped busy request in the first one.
    do_accept(0, 8'hA5);
    frame_check(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    d_in     = 8'h3C;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    check("b2b_done_one_clk", done_v[0], 8'd0);
    check("b2b_ready_drop", ready_v[0], 8'd0);
    frame_check(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    post_done(0);
    idle_watch(0, 200);

    do_accept(3, 8'h00);
    frame_check(3, 8'h00, 1'b0, 1'b0, 1'b0);
    post_done(3);

    do_accept(0, 8'hC3);
    frame_check(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    idle_watch(0, 100);
    do_accept(0, 8'h55);
    frame_check(0, 8'h55, 1'b0, 1'b0, 1'b0);
    post_done(0);

    rb = 8'($urandom);
    do_accept(1, rb);
    frame_check(1, rb, 1'b0, 1'b1, 1'b0);
    post_done(1);

    for (int i = 0; i < 12; i++) begin
      rk = int'($urandom_range(0, 3));
      rb = 8'($urandom);
      repeat ($urandom_range(0, 7)) @(posedge clk);
      do_accept(rk, rb);
      frame_check(rk, rb, 1'b0, 1'b0, 1'b0);
      post_done(rk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
